// File: rtl/rasterizer_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rasterizer_arb_pkg
// Purpose  : Shared types for the rasterizer memory arbiter (requester IDs,
//            grant-lock states).
// Revision : 1.0 - initial release
// ============================================================================
package rasterizer_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic {
        REQ_VTX = 1'b0,
        REQ_PIX = 1'b1
    } req_id_t;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT0 = 2'd1,
        ARB_GRANT1 = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rasterizer_arb_id_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rasterizer_arb_id_fifo
// Purpose  : In-order FIFO of requester IDs for reads in flight; push and pop
//            may coincide when full, pop on empty is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module rasterizer_arb_id_fifo
    import rasterizer_arb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  req_id_t                push_id,
    input  logic                   pop,
    output req_id_t                head_id,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    req_id_t          r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty   = (r_count == '0);
    assign full    = (r_count == (PTR_W+1)'(DEPTH));
    assign count   = r_count;
    assign head_id = r_mem[r_rd_ptr];

    // A pop in the same cycle frees the slot the push needs.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/rasterizer_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rasterizer_mem_arbiter
// Purpose  : Shares one Avalon-MM master between vertex fetch (s0) and pixel
//            writer (s1); routes read beats back in order via an ID FIFO.
//            Define RASTERIZER_ARB_FIXED_PRIORITY_EN for fixed s0 priority.
// Revision : 1.0 - initial release
// ============================================================================
module rasterizer_mem_arbiter
    import rasterizer_arb_pkg::*;
#(
    parameter int ADDR_W          = 26,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                             clock,
    input  logic                             reset,

    input  logic [ADDR_W-1:0]                s0_address,
    input  logic                             s0_read,
    input  logic                             s0_write,
    input  logic [3:0]                       s0_byteenable,
    input  logic [DATA_W-1:0]                s0_writedata,
    output logic                             s0_waitrequest,
    output logic [DATA_W-1:0]                s0_readdata,
    output logic                             s0_readdatavalid,

    input  logic [ADDR_W-1:0]                s1_address,
    input  logic                             s1_read,
    input  logic                             s1_write,
    input  logic [3:0]                       s1_byteenable,
    input  logic [DATA_W-1:0]                s1_writedata,
    output logic                             s1_waitrequest,
    output logic [DATA_W-1:0]                s1_readdata,
    output logic                             s1_readdatavalid,

    output logic [ADDR_W-1:0]                master_address,
    output logic                             master_read,
    output logic                             master_write,
    output logic [3:0]                       master_byteenable,
    output logic [DATA_W-1:0]                master_writedata,
    input  logic                             master_waitrequest,
    input  logic [DATA_W-1:0]                master_readdata,
    input  logic                             master_readdatavalid,

    output logic [$clog2(MAX_OUTSTANDING):0] outstanding
);

    arb_state_t           r_lock;
    logic [NUM_REQ-1:0]   w_req;
    logic                 w_gnt_valid;
    req_id_t              w_gnt_id;
    logic                 w_sel_read;
    logic                 w_sel_write;
    logic                 w_is_read;
    logic                 w_stall;
    logic                 w_accept;
    logic                 w_fifo_block;
    logic                 w_rdv_ok;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    req_id_t              w_head_id;

`ifndef RASTERIZER_ARB_FIXED_PRIORITY_EN
    req_id_t              r_rr_last;
`endif

    assign w_req[0] = s0_read | s0_write;
    assign w_req[1] = s1_read | s1_write;

    // A held lock wins outright; otherwise arbitrate among current requests.
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_id    = REQ_VTX;
        if (!reset) begin
            if (r_lock == ARB_GRANT0 && w_req[0]) begin
                w_gnt_valid = 1'b1;
                w_gnt_id    = REQ_VTX;
            end else if (r_lock == ARB_GRANT1 && w_req[1]) begin
                w_gnt_valid = 1'b1;
                w_gnt_id    = REQ_PIX;
            end else if (w_req[0] && w_req[1]) begin
                w_gnt_valid = 1'b1;
`ifdef RASTERIZER_ARB_FIXED_PRIORITY_EN
                w_gnt_id    = REQ_VTX;
`else
                w_gnt_id    = (r_rr_last == REQ_VTX) ? REQ_PIX : REQ_VTX;
`endif
            end else if (w_req[0]) begin
                w_gnt_valid = 1'b1;
                w_gnt_id    = REQ_VTX;
            end else if (w_req[1]) begin
                w_gnt_valid = 1'b1;
                w_gnt_id    = REQ_PIX;
            end
        end
    end

    always_comb begin
        w_sel_read        = s0_read;
        w_sel_write       = s0_write;
        master_address    = s0_address;
        master_byteenable = s0_byteenable;
        master_writedata  = s0_writedata;
        if (w_gnt_id == REQ_PIX) begin
            w_sel_read        = s1_read;
            w_sel_write       = s1_write;
            master_address    = s1_address;
            master_byteenable = s1_byteenable;
            master_writedata  = s1_writedata;
        end
    end

    // Read wins when both strobes are set on one port.
    assign w_is_read    = w_gnt_valid & w_sel_read;
    assign master_read  = w_is_read;
    assign master_write = w_gnt_valid & w_sel_write & ~w_sel_read;

    // A full FIFO only blocks a read when no beat retires in the same cycle.
    assign w_rdv_ok     = master_readdatavalid & ~reset & ~w_fifo_empty;
    assign w_fifo_block = w_fifo_full & ~w_rdv_ok;
    assign w_stall      = master_waitrequest | (w_is_read & w_fifo_block);
    assign w_accept     = w_gnt_valid & ~w_stall;

    assign s0_waitrequest = ~(w_gnt_valid && w_gnt_id == REQ_VTX) | w_stall;
    assign s1_waitrequest = ~(w_gnt_valid && w_gnt_id == REQ_PIX) | w_stall;

    assign s0_readdata      = master_readdata;
    assign s1_readdata      = master_readdata;
    assign s0_readdatavalid = w_rdv_ok & (w_head_id == REQ_VTX);
    assign s1_readdatavalid = w_rdv_ok & (w_head_id == REQ_PIX);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_lock <= ARB_IDLE;
        end else if (w_gnt_valid && !w_accept) begin
            r_lock <= (w_gnt_id == REQ_PIX) ? ARB_GRANT1 : ARB_GRANT0;
        end else begin
            r_lock <= ARB_IDLE;
        end
    end

`ifndef RASTERIZER_ARB_FIXED_PRIORITY_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr_last <= REQ_PIX;
        end else if (w_accept) begin
            r_rr_last <= w_gnt_id;
        end
    end
`endif

    rasterizer_arb_id_fifo #(
        .DEPTH   (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (clock),
        .rst     (reset),
        .push    (w_accept & w_is_read),
        .push_id (w_gnt_id),
        .pop     (master_readdatavalid & ~reset),
        .head_id (w_head_id),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty),
        .count   (outstanding)
    );

endmodule
`default_nettype wire

// File: tb/tb_rasterizer_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rasterizer_mem_arbiter
// Purpose  : Directed bench with a queue-based reference model of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rasterizer_mem_arbiter;

    localparam int ADDR_W = 26;
    localparam int DATA_W = 32;
    localparam int MAXO   = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] s0_address = '0, s1_address = '0;
    logic              s0_read = 1'b0, s0_write = 1'b0, s1_read = 1'b0, s1_write = 1'b0;
    logic [3:0]        s0_byteenable = '0, s1_byteenable = '0;
    logic [DATA_W-1:0] s0_writedata = '0, s1_writedata = '0;
    logic              s0_waitrequest, s1_waitrequest;
    logic [DATA_W-1:0] s0_readdata, s1_readdata;
    logic              s0_readdatavalid, s1_readdatavalid;
    logic [ADDR_W-1:0] master_address;
    logic              master_read, master_write;
    logic [3:0]        master_byteenable;
    logic [DATA_W-1:0] master_writedata;
    logic              master_waitrequest = 1'b0;
    logic [DATA_W-1:0] master_readdata = '0;
    logic              master_readdatavalid = 1'b0;
    logic [$clog2(MAXO):0] outstanding;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    rasterizer_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clock(clock), .reset(reset),
        .s0_address(s0_address), .s0_read(s0_read), .s0_write(s0_write),
        .s0_byteenable(s0_byteenable), .s0_writedata(s0_writedata),
        .s0_waitrequest(s0_waitrequest), .s0_readdata(s0_readdata),
        .s0_readdatavalid(s0_readdatavalid),
        .s1_address(s1_address), .s1_read(s1_read), .s1_write(s1_write),
        .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_waitrequest(s1_waitrequest), .s1_readdata(s1_readdata),
        .s1_readdatavalid(s1_readdatavalid),
        .master_address(master_address), .master_read(master_read),
        .master_write(master_write), .master_byteenable(master_byteenable),
        .master_writedata(master_writedata), .master_waitrequest(master_waitrequest),
        .master_readdata(master_readdata), .master_readdatavalid(master_readdatavalid),
        .outstanding(outstanding)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int granted();
        if (!s0_waitrequest) return 0;
        if (!s1_waitrequest) return 1;
        return -1;
    endfunction

    // Reference model: in-order queue of requester IDs plus arbitration rules.
    bit m_q[$];
    int m_lock = -1;
    int m_rr   = 1;

    always @(negedge clock) begin : cmp
        bit                rq[2], rd[2], wr[2];
        logic [ADDR_W-1:0] ad[2];
        logic [3:0]        be[2];
        logic [DATA_W-1:0] wd[2];
        int  g;
        bit  pop, full, is_rd, is_wr, blk, acc;
        rd[0] = s0_read;  wr[0] = s0_write; ad[0] = s0_address; be[0] = s0_byteenable; wd[0] = s0_writedata;
        rd[1] = s1_read;  wr[1] = s1_write; ad[1] = s1_address; be[1] = s1_byteenable; wd[1] = s1_writedata;
        rq[0] = rd[0] | wr[0];
        rq[1] = rd[1] | wr[1];
        if (reset) begin
            chk("m_rst_wait", {s1_waitrequest, s0_waitrequest}, 2'b11);
            chk("m_rst_rdv", {s1_readdatavalid, s0_readdatavalid}, 2'b00);
            chk("m_rst_mcmd", {master_read, master_write}, 2'b00);
            m_q.delete();
            m_lock = -1;
            m_rr   = 1;
        end else begin
            g = -1;
            if (m_lock >= 0 && rq[m_lock]) g = m_lock;
`ifdef RASTERIZER_ARB_FIXED_PRIORITY_EN
            else if (rq[0] && rq[1]) g = 0;
`else
            else if (rq[0] && rq[1]) g = (m_rr == 0) ? 1 : 0;
`endif
            else if (rq[0]) g = 0;
            else if (rq[1]) g = 1;
            pop   = master_readdatavalid && (m_q.size() > 0);
            full  = (m_q.size() == MAXO);
            is_rd = (g >= 0) && rd[g];
            is_wr = (g >= 0) && !rd[g] && wr[g];
            blk   = is_rd && full && !pop;
            acc   = (g >= 0) && !master_waitrequest && !blk;
            chk("m_wait0", s0_waitrequest, (g == 0) ? (master_waitrequest | blk) : 1'b1);
            chk("m_wait1", s1_waitrequest, (g == 1) ? (master_waitrequest | blk) : 1'b1);
            chk("m_mread", master_read, is_rd);
            chk("m_mwrite", master_write, is_wr);
            if (g >= 0) begin
                chk("m_maddr", master_address, ad[g]);
                chk("m_mbe", master_byteenable, be[g]);
                if (is_wr) chk("m_mwdata", master_writedata, wd[g]);
            end
            chk("m_rdv0", s0_readdatavalid, pop && (m_q[0] == 1'b0));
            chk("m_rdv1", s1_readdatavalid, pop && (m_q[0] == 1'b1));
            chk("m_rdata0", s0_readdata, master_readdata);
            chk("m_rdata1", s1_readdata, master_readdata);
            chk("m_outst", outstanding, m_q.size());
            if (pop) void'(m_q.pop_front());
            if (acc && is_rd) m_q.push_back(g[0]);
            m_lock = (g >= 0 && !acc) ? g : -1;
            if (acc) m_rr = g;
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) cyc();
        chk("t0_rst_wait", {s1_waitrequest, s0_waitrequest}, 2'b11);
        chk("t0_rst_rdv", {s1_readdatavalid, s0_readdatavalid}, 2'b00);
        reset = 1'b0;
        #1;
        chk("t0_outst", outstanding, 0);

        // Solo s0 read, beat three cycles later
        s0_read = 1'b1; s0_address = 26'h100; s0_byteenable = 4'hF;
        #1;
        chk("t1_accept", {master_read, s0_waitrequest}, 2'b10);
        chk("t1_addr", master_address, 26'h100);
        cyc();
        s0_read = 1'b0;
        cyc();
        cyc();
        master_readdatavalid = 1'b1; master_readdata = 32'hDEADBEEF;
        #1;
        chk("t1_rdv", {s1_readdatavalid, s0_readdatavalid}, 2'b01);
        chk("t1_data", s0_readdata, 32'hDEADBEEF);
        cyc();
        master_readdatavalid = 1'b0;

        // Both ports read continuously: alternating grants
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        s0_read = 1'b1; s0_address = 26'h10;
        s1_read = 1'b1; s1_address = 26'h20;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_grant", granted(), i % 2);
            cyc();
        end
        s0_read = 1'b0; s1_read = 1'b0;
        for (int i = 0; i < 4; i++) begin
            master_readdatavalid = 1'b1; master_readdata = 32'hA0 + i;
            #1;
            chk("t2_route", {s1_readdatavalid, s0_readdatavalid}, (i % 2) ? 2'b10 : 2'b01);
            cyc();
        end
        master_readdatavalid = 1'b0;

        // s1 write stalled four cycles while s0 also requests
        s1_write = 1'b1; s1_address = 26'h3000; s1_writedata = 32'hCAFEF00D;
        s1_byteenable = 4'h3; master_waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i >= 1) begin
                s0_read = 1'b1; s0_address = 26'h40;
            end
            #1;
            chk("t3_hold_wr", master_write, 1'b1);
            chk("t3_hold_addr", master_address, 26'h3000);
            chk("t3_hold_wd", master_writedata, 32'hCAFEF00D);
            chk("t3_hold_wait", {s1_waitrequest, s0_waitrequest}, 2'b11);
            cyc();
        end
        master_waitrequest = 1'b0;
        #1;
        chk("t3_wr_accept", {master_write, s1_waitrequest, s0_waitrequest}, 3'b101);
        cyc();
        s1_write = 1'b0;
        #1;
        chk("t3_s0_next", {master_read, s0_waitrequest}, 2'b10);
        cyc();
        s0_read = 1'b0;
        master_readdatavalid = 1'b1; master_readdata = 32'h55;
        #1;
        chk("t3_rdv", {s1_readdatavalid, s0_readdatavalid}, 2'b01);
        cyc();
        master_readdatavalid = 1'b0;

        // Fill the ID FIFO, ninth read waits until a beat retires
        s0_read = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s0_address = 26'h200 + i;
            #1;
            chk("t4_fill", s0_waitrequest, 1'b0);
            cyc();
        end
        s0_address = 26'h300;
        #1;
        chk("t4_full_wait", s0_waitrequest, 1'b1);
        chk("t4_full_cnt", outstanding, 8);
        cyc();
        master_readdatavalid = 1'b1; master_readdata = 32'h900;
        #1;
        chk("t4_swap_acc", {master_read, s0_waitrequest, s0_readdatavalid}, 3'b101);
        cyc();
        s0_read = 1'b0; master_readdatavalid = 1'b0;
        #1;
        chk("t4_swap_cnt", outstanding, 8);
        for (int i = 0; i < 8; i++) begin
            master_readdatavalid = 1'b1; master_readdata = 32'h910 + i;
            cyc();
        end
        master_readdatavalid = 1'b0;
        #1;
        chk("t4_drained", outstanding, 0);

        // Reset with reads in flight, then stray beats
        s1_read = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s1_address = 26'h400 + i;
            cyc();
        end
        s1_read = 1'b0;
        #1;
        chk("t5_pre_cnt", outstanding, 4);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        chk("t5_post_cnt", outstanding, 0);
        for (int i = 0; i < 2; i++) begin
            master_readdatavalid = 1'b1; master_readdata = 32'hBAD0 + i;
            #1;
            chk("t5_stray", {s1_readdatavalid, s0_readdatavalid}, 2'b00);
            cyc();
        end
        master_readdatavalid = 1'b0;
        #1;
        chk("t5_stray_cnt", outstanding, 0);
        s1_read = 1'b1; s1_address = 26'h500;
        #1;
        chk("t5_fresh_acc", s1_waitrequest, 1'b0);
        cyc();
        s1_read = 1'b0;
        cyc();
        master_readdatavalid = 1'b1; master_readdata = 32'h12345678;
        #1;
        chk("t5_fresh_rdv", {s1_readdatavalid, s0_readdatavalid}, 2'b10);
        chk("t5_fresh_data", s1_readdata, 32'h12345678);
        cyc();
        master_readdatavalid = 1'b0;

        // Contested window of five cycles
        s0_read = 1'b1; s0_address = 26'h600;
        s1_read = 1'b1; s1_address = 26'h700;
        for (int i = 0; i < 5; i++) begin
            #1;
`ifdef RASTERIZER_ARB_FIXED_PRIORITY_EN
            chk("t6_fixed_grant", granted(), 0);
`else
            chk("t6_rr_grant", granted(), i % 2);
`endif
            cyc();
        end
        s0_read = 1'b0; s1_read = 1'b0;
        for (int i = 0; i < 5; i++) begin
            master_readdatavalid = 1'b1; master_readdata = 32'hB0 + i;
            cyc();
        end
        master_readdatavalid = 1'b0;
        #1;
        chk("t6_drained", outstanding, 0);
        cyc();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rasterizer_mem_arbiter.md
Name: rasterizer_mem_arbiter

Overview:
- Shares one Avalon-MM master port (26-bit word-aligned address, 32-bit data) between two rasterizer requesters.
- Port s0 is the vertex fetch unit; port s1 is the framebuffer/pixel writer.
- Arbitrates single-word reads and writes, supports pipelined reads with variable latency, and routes each readdatavalid beat back to the requester that issued it, using an in-order ID FIFO.

Parameters:
ADDR_W, 26, address width on all ports
DATA_W, 32, data width on all ports
MAX_OUTSTANDING, 8, max reads in flight (ID FIFO depth, power of 2, >=2)

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
sN_address  in  ADDR_W  requester N address (N=0,1)
sN_read  in  1  requester N read request
sN_write  in  1  requester N write request
sN_byteenable  in  4  requester N byte enables
sN_writedata  in  DATA_W  requester N write data
sN_waitrequest  out  1  requester N stall
sN_readdata  out  DATA_W  requester N read data
sN_readdatavalid  out  1  requester N read data valid
master_address  out  ADDR_W  to interconnect
master_read  out  1  to interconnect
master_write  out  1  to interconnect
master_byteenable  out  4  to interconnect
master_writedata  out  DATA_W  to interconnect
master_waitrequest  in  1  interconnect stall
master_readdata  in  DATA_W  interconnect read data
master_readdatavalid  in  1  interconnect read data valid
outstanding  out  $clog2(MAX_OUTSTANDING)+1  reads in flight (debug)

Behaviour:
Reset
- Clock and reset: one clock; reset is synchronous and active-high, sampled on posedge clock.
- On reset: ID FIFO empty, outstanding=0, rr_last=1 (so s0 wins first), grant lock cleared.
- Outputs during and after reset: sN_readdatavalid=0 and sN_waitrequest=1 while reset is high.

Requests and acceptance
- A requester "requests" when sN_read|sN_write. Read and write asserted together on one port is illegal; read takes precedence.
- Accept = granted request && !master_waitrequest && !(read && fifo_full). Transfer occurs on that posedge.
- Master outputs are combinational muxes of the granted port. When no port is granted, master_read=master_write=0.
- Granted port: sN_waitrequest = master_waitrequest | (sN_read & fifo_full). Non-granted port: waitrequest=1.

Arbitration
- Round-robin when both ports request; the port not served last wins.
- Lock: once a granted request is stalled, grant is held until that request is accepted or deasserted. No re-arbitration mid-stall (Avalon hold rule).
- rr_last updates only on accept.
- Zero added latency: a request presented with master_waitrequest=0 and a free FIFO is accepted in the same cycle.

Read tracking and return
- On an accepted read, push the requester ID (1 bit) into the FIFO.
- On master_readdatavalid: pop the head ID and assert that port's sN_readdatavalid combinationally in the same cycle. sN_readdata = master_readdata is broadcast to both ports.
- Simultaneous push and pop: occupancy unchanged. Allowed when full (pop frees the slot), so accept when full is permitted if master_readdatavalid=1 that cycle.
- Writes never enter the FIFO.
- outstanding = FIFO occupancy, saturating at 0..MAX_OUTSTANDING.
- readdatavalid while FIFO empty (e.g. a beat returning after a mid-flight reset): beat dropped, no sN_readdatavalid, no underflow.

Reset mid-operation
- In-flight IDs are discarded and late beats are dropped per the empty-FIFO rule above.

Optional Feature:
- Macro RASTERIZER_ARB_FIXED_PRIORITY_EN.
- Defined: s0 (vertex fetch) always wins a contested cycle and rr_last is unused. Lock rule still applies, so a stalled s1 grant is not pre-empted.
- Undefined: round-robin as above.

Decomposition:
- Package rasterizer_arb_pkg holds:
  - typedef enum logic {REQ_VTX=0, REQ_PIX=1} req_id_t
  - localparam NUM_REQ=2
  - typedef enum logic[1:0] {ARB_IDLE, ARB_GRANT0, ARB_GRANT1} arb_state_t for the grant lock
- Sub-module rasterizer_arb_id_fifo: synchronous FIFO of req_id_t.
  - Depth MAX_OUTSTANDING; push/pop/full/empty/count.
  - Simultaneous push and pop allowed when full; pop when empty is ignored.

Test Plan:
- Solo s0 read at addr 0x100, master_waitrequest=0, readdatavalid 3 cycles later with 0xDEADBEEF -> accepted cycle 0, s0_readdatavalid=1 with 0xDEADBEEF, s1_readdatavalid stays 0.
- s0 and s1 both read continuously, no stall -> grants alternate s0,s1,s0,s1; returned beats 0xA0,0xA1,0xA2,0xA3 reach s0,s1,s0,s1 in order.
- s1 write held under master_waitrequest for 4 cycles while s0 also requests -> grant stays on s1, master_address/writedata stable, s0_waitrequest=1 throughout; s0 granted the cycle after the write is accepted.
- Issue 8 reads with no return -> 9th read sees waitrequest=1 and outstanding=8; on the cycle readdatavalid=1, the 9th read is accepted and outstanding stays 8.
- 4 reads outstanding, reset pulsed 1 cycle, then 2 stray readdatavalid beats -> no sN_readdatavalid, outstanding=0; a fresh s1 read then returns correctly to s1.
- With RASTERIZER_ARB_FIXED_PRIORITY_EN, both ports requesting for 5 cycles -> all 5 grants go to s0.
